// File: rtl/radix8_ntt_sequencer.sv
// radix8_ntt_sequencer: issues radix-8 butterfly groups stage by stage and retires their write-backs.
module radix8_ntt_sequencer #(
  parameter int LOG8_N = 2,
  parameter int ADDR_W = 3*LOG8_N,
  parameter int RD_LAT = 1,
  localparam int SW = LOG8_N > 1 ? $clog2(LOG8_N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              inverse,
  input  logic              ready_in,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_base,
  output logic [ADDR_W-1:0] rd_stride,
  output logic [ADDR_W-1:0] tw_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_base,
  output logic [ADDR_W-1:0] wr_stride,
  output logic [SW-1:0]     stage,
  output logic [1:0]        select_mode,
  output logic              ntt_intt_mode
);
  localparam int N = 1 << (3*LOG8_N);
  localparam int PIPE = RD_LAT + 1;
  localparam int CW = $clog2(PIPE+1) + 1;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, BARRIER = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [SW-1:0] stage_q;
  logic [ADDR_W-1:0] g, span, k, blk, base, tw;
  logic inv_q;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PIPE-1:0] wen_p;
  logic [ADDR_W-1:0] wb_p [PIPE];
  logic [ADDR_W-1:0] ws_p [PIPE];
  int sh;
  // span is a power of 8, so block/offset split is a pure shift and mask
  always_comb begin
    sh = 3*(LOG8_N-1-int'(stage_q));
    span = ADDR_W'(1) << sh;
    k = g & (span - ADDR_W'(1));
    blk = g >> sh;
    base = (blk << (sh+3)) | k;
    tw = (k << (3*int'(stage_q))) & ADDR_W'(N-1);
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign rd_en = state == ISSUE && ready_in;
  assign rd_base = busy ? base : '0;
  assign rd_stride = busy ? span : '0;
  assign tw_idx = busy ? tw : '0;
  assign stage = stage_q;
  assign select_mode = busy ? 2'b10 : 2'b00;
  assign ntt_intt_mode = busy & inv_q;
  assign wr_en = wen_p[PIPE-1];
  assign wr_base = wb_p[PIPE-1];
  assign wr_stride = ws_p[PIPE-1];
  assign cnt_nxt = cnt + CW'(rd_en) - CW'(wr_en);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      stage_q <= '0;
      g <= '0;
      inv_q <= 1'b0;
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
      case (state)
        IDLE: if (start) begin
          state <= ISSUE;
          stage_q <= '0;
          g <= '0;
          inv_q <= inverse;
        end
        ISSUE: if (ready_in) begin
          g <= g == ADDR_W'(N/8-1) ? '0 : g + ADDR_W'(1);
          if (g == ADDR_W'(N/8-1)) state <= BARRIER;
        end
        // barrier releases on the cycle the final outstanding write-back retires
        BARRIER: if (cnt_nxt == '0) begin
          if (stage_q == SW'(LOG8_N-1)) state <= DONE;
          else begin
            state <= ISSUE;
            stage_q <= stage_q + SW'(1);
            g <= '0;
          end
        end
        default: begin
          state <= IDLE;
          stage_q <= '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_p <= '0;
      for (int i = 0; i < PIPE; i++) begin
        wb_p[i] <= '0;
        ws_p[i] <= '0;
      end
    end else begin
      wen_p[0] <= rd_en;
      wb_p[0] <= rd_base;
      ws_p[0] <= rd_stride;
      for (int i = 1; i < PIPE; i++) begin
        wen_p[i] <= wen_p[i-1];
        wb_p[i] <= wb_p[i-1];
        ws_p[i] <= ws_p[i-1];
      end
    end
  end
endmodule

// File: doc/radix8_ntt_sequencer.md
Name: radix8_ntt_sequencer

Overview:
- Sequences the combined radix-8 butterfly datapath through one full forward or inverse NTT of N = 8^LOG8_N coefficients held in a banked coefficient memory.
- Each cycle it issues at most one butterfly group: a read base address, a stride, a twiddle exponent index, and the `select_mode`/`NTT_INTT_mode` controls the butterfly consumes.
- It issues the matching write-back a fixed number of cycles later.
- It enforces a barrier between stages so no stage reads data the previous stage has not yet written.
- Sits between the top-level NTT controller (start/done) and the memory + twiddle ROM + butterfly datapath.

Parameters:
- LOG8_N, 2, number of radix-8 stages; N = 8^LOG8_N (default 64 points).
- ADDR_W, 3*LOG8_N, coefficient address width.
- RD_LAT, 1, cycles from rd_en to butterfly inputs valid; the butterfly adds one register stage.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- inverse  in  1  0 = NTT, 1 = INTT; latched on accepted start.
- ready_in  in  1  datapath/memory can accept an issue this cycle.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse when the last write-back has retired.
- rd_en  out  1  issue strobe for one butterfly group.
- rd_base  out  ADDR_W  address of butterfly input 1; input i is at rd_base + (i-1)*rd_stride.
- rd_stride  out  ADDR_W  element spacing of the group.
- tw_idx  out  ADDR_W  twiddle exponent for this group (psi/w ROM index).
- wr_en  out  1  write-back strobe.
- wr_base  out  ADDR_W  write-back base address, in-place.
- wr_stride  out  ADDR_W  write-back stride.
- stage  out  max(1,clog2(LOG8_N))  current stage number.
- select_mode  out  2  butterfly mode; 2'b10 (radix-8) while busy, 2'b00 otherwise.
- ntt_intt_mode  out  1  latched `inverse`, valid while busy.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; all counters clear.
  - busy, done, rd_en, wr_en, ntt_intt_mode = 0; rd_base, rd_stride, tw_idx, wr_base, wr_stride, stage = 0; select_mode = 2'b00.
  - Reset mid-transform abandons all in-flight groups: no wr_en after reset is released.
- FSM states: IDLE, ISSUE, BARRIER, DONE.
  - IDLE --start--> ISSUE: stage = 0, group counter g = 0, inverse latched.
  - ISSUE: on each cycle with ready_in=1, assert rd_en with the current address fields and advance g. If ready_in=0, rd_en=0 and all fields hold. After g = N/8-1 issues, go to BARRIER.
  - BARRIER: wait until the in-flight count reaches 0. Then, if stage < LOG8_N-1, increment stage, set g = 0 and go to ISSUE (first issue is the next cycle); otherwise go to DONE.
  - DONE: done=1 for one cycle, busy still 1; then go to IDLE.
- Address generation, DIF order:
  - span = 8^(LOG8_N-1-stage); blk = g / span; k = g mod span (bit slices, since span is a power of 8).
  - rd_base = blk*8*span + k; rd_stride = span; tw_idx = k * 8^stage mod N.
- Write-back:
  - Fixed pipeline of PIPE = RD_LAT+1 cycles.
  - wr_en/wr_base/wr_stride equal rd_en/rd_base/rd_stride delayed by exactly PIPE cycles.
  - This pipeline is unaffected by ready_in.
- In-flight count: increments on rd_en, decrements on wr_en; a simultaneous rd_en and wr_en leaves it unchanged. It never exceeds PIPE.
- start while busy, or in the DONE cycle, is ignored. inverse changes while busy have no effect.
- Throughput with ready_in held 1:
  - Cycles from accepted start to done = 1 + LOG8_N*(N/8 + PIPE).
  - done may be followed immediately by an accepted start: the IDLE cycle after DONE samples start.

Test Plan:
- Default params, RD_LAT=1, ready_in=1, start pulse at cycle 0:
  - rd_en high cycles 1–8 with rd_base 0..7, rd_stride 8, tw_idx 0..7.
  - wr_en cycles 3–10 with the same addresses.
  - rd_en cycles 11–18 with rd_base 0,8,...,56, stride 1, tw_idx 0.
  - wr_en cycles 13–20; done=1 only at cycle 21; busy high cycles 1–21.
- inverse=1 at start, then 0 one cycle later: ntt_intt_mode=1 for the whole run; select_mode=2'b10 during busy and 2'b00 before and after.
- ready_in=0 on cycles 3–5 of stage 0:
  - No rd_en in those cycles; the issue sequence resumes at the held rd_base.
  - Stage 1 does not issue until 1 cycle after the last stage-0 wr_en; done slips by exactly 3 cycles (cycle 24).
- start pulses during busy, e.g. cycle 5: no restart, counters undisturbed, exactly 16 rd_en and 16 wr_en total.
- rst_n low at cycle 7 for 2 cycles: all outputs 0 immediately (async), no wr_en afterwards. A fresh start then reproduces scenario 1 exactly.
- Back-to-back: start asserted in the cycle after done → second transform begins; its rd_en sequence matches scenario 1, offset by 22 cycles.
